// File: rtl/bullet_hit_tracker.sv
// rtl/bullet_hit_tracker.sv - per-frame bullet/enemy hit detection, enemy life cycle and BCD score
module bullet_hit_tracker #(
    parameter int unsigned EXPLODE_FRAMES = 8,
    parameter int unsigned RESPAWN_FRAMES = 60,
    parameter logic [3:0]  SCORE_STEP     = 4'd1
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        score_clear,
    input  logic [9:0]  BulletX,
    input  logic [9:0]  BulletY,
    input  logic [9:0]  BulletS,
    input  logic        bullet_on,
    input  logic [9:0]  EnemyX,
    input  logic [9:0]  EnemyY,
    input  logic [9:0]  EnemyS,
    output logic        hit,
    output logic        enemy_alive,
    output logic        enemy_exploding,
    output logic [2:0]  explode_frame,
    output logic [15:0] Score
);

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        EXPLODING = 2'd1,
        RESPAWN   = 2'd2
    } state_t;

    localparam logic [7:0] EXPLODE_LAST = 8'(EXPLODE_FRAMES - 1);
    localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);

    state_t      state;
    logic [7:0]  frame_cnt;
    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] reach;
    logic        ov;
    logic        fire;

    // Distances and reach are widened to 11 bits so neither can wrap.
    always_comb begin
        dx    = (BulletX >= EnemyX) ? {1'b0, BulletX - EnemyX} : {1'b0, EnemyX - BulletX};
        dy    = (BulletY >= EnemyY) ? {1'b0, BulletY - EnemyY} : {1'b0, EnemyY - BulletY};
        reach = {1'b0, BulletS} + {1'b0, EnemyS};
        ov    = (dx < reach) && (dy < reach);
        fire  = (state == ALIVE) && bullet_on && ov;
    end

    // Packed-BCD add of a single-digit step; any carry out of the thousands digit saturates.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] s, input logic [3:0] step);
        logic [15:0] r;
        logic [4:0]  d;
        logic        c;
        r = 16'h0000;
        c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, s[4*i +: 4]} + ((i == 0) ? {1'b0, step} : 5'd0) + {4'd0, c};
            if (d > 5'd9) begin
                r[4*i +: 4] = 4'(d - 5'd10);
                c           = 1'b1;
            end else begin
                r[4*i +: 4] = d[3:0];
                c           = 1'b0;
            end
        end
        return c ? 16'h9999 : r;
    endfunction

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state     <= ALIVE;
            frame_cnt <= 8'd0;
            hit       <= 1'b0;
            Score     <= 16'h0000;
        end else begin
            hit <= 1'b0;
            case (state)
                ALIVE: begin
                    frame_cnt <= 8'd0;
                    if (fire) begin
                        state <= EXPLODING;
                        hit   <= 1'b1;
                    end
                end
                EXPLODING: begin
                    if (frame_cnt == EXPLODE_LAST) begin
                        state     <= RESPAWN;
                        frame_cnt <= 8'd0;
                    end else begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                RESPAWN: begin
                    if (frame_cnt == RESPAWN_LAST) begin
                        state     <= ALIVE;
                        frame_cnt <= 8'd0;
                    end else begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= ALIVE;
                    frame_cnt <= 8'd0;
                end
            endcase

            // A clear on the same edge as a hit wins; the hit pulse itself still fires.
            if (score_clear) begin
                Score <= 16'h0000;
            end else if (fire) begin
                Score <= bcd_add_sat(Score, SCORE_STEP);
            end
        end
    end

    assign enemy_alive     = (state == ALIVE);
    assign enemy_exploding = (state == EXPLODING);
    assign explode_frame   = (state == EXPLODING) ? frame_cnt[2:0] : 3'd0;

endmodule

// File: tb/tb_bullet_hit_tracker.sv
// tb/tb_bullet_hit_tracker.sv - self-checking bench for bullet_hit_tracker
module tb_bullet_hit_tracker;

    logic frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    logic        Reset;
    logic        score_clear;
    logic        bullet_on;
    logic [9:0]  BulletX, BulletY, BulletS, EnemyX, EnemyY, EnemyS;
    logic        hit, enemy_alive, enemy_exploding;
    logic [2:0]  explode_frame;
    logic [15:0] Score;

    logic        f_on;
    logic        f_hit, f_alive, f_expl;
    logic [2:0]  f_ef;
    logic [15:0] f_score;

    int n_checks = 0;
    int n_fail   = 0;
    int f_hits   = 0;

    bullet_hit_tracker dut (
        .frame_clk(frame_clk), .Reset(Reset), .score_clear(score_clear),
        .BulletX(BulletX), .BulletY(BulletY), .BulletS(BulletS), .bullet_on(bullet_on),
        .EnemyX(EnemyX), .EnemyY(EnemyY), .EnemyS(EnemyS),
        .hit(hit), .enemy_alive(enemy_alive), .enemy_exploding(enemy_exploding),
        .explode_frame(explode_frame), .Score(Score)
    );

    // Short life cycle so the score can be driven to saturation within a small cycle budget.
    bullet_hit_tracker #(.EXPLODE_FRAMES(1), .RESPAWN_FRAMES(1), .SCORE_STEP(4'd1)) dut_f (
        .frame_clk(frame_clk), .Reset(Reset), .score_clear(1'b0),
        .BulletX(10'd50), .BulletY(10'd50), .BulletS(10'd5), .bullet_on(f_on),
        .EnemyX(10'd52), .EnemyY(10'd50), .EnemyS(10'd5),
        .hit(f_hit), .enemy_alive(f_alive), .enemy_exploding(f_expl),
        .explode_frame(f_ef), .Score(f_score)
    );

    // Model: frames elapsed since the last hit (-1 = alive) and a plain decimal score.
    int m_since [2];
    int m_score [2];
    bit m_hit   [2];
    int EF [2] = '{8, 1};
    int RF [2] = '{60, 1};
    int STEP = 1;

    function automatic bit overlap(input int bx, input int by, input int bs,
                                   input int ex, input int ey, input int es);
        int dx, dy;
        dx = (bx > ex) ? bx - ex : ex - bx;
        dy = (by > ey) ? by - ey : ey - by;
        return (dx < bs + es) && (dy < bs + es);
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic model_step(input int i, input bit on, input bit ov, input bit clr);
        bit fire;
        fire = (m_since[i] < 0) && on && ov;
        m_hit[i] = fire;
        if (m_since[i] >= 0) begin
            m_since[i]++;
            if (m_since[i] == EF[i] + RF[i]) m_since[i] = -1;
        end
        if (fire) m_since[i] = 0;
        if (clr) m_score[i] = 0;
        else if (fire) m_score[i] = (m_score[i] + STEP > 9999) ? 9999 : m_score[i] + STEP;
    endtask

    always @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 2; i++) begin
                m_since[i] = -1;
                m_score[i] = 0;
                m_hit[i]   = 1'b0;
            end
        end else begin
            model_step(0, bullet_on, overlap(int'(BulletX), int'(BulletY), int'(BulletS),
                                             int'(EnemyX), int'(EnemyY), int'(EnemyS)), score_clear);
            model_step(1, f_on, overlap(50, 50, 5, 52, 50, 5), 1'b0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] m_ef(input int i);
        return (m_since[i] >= 0 && m_since[i] < EF[i]) ? 3'(m_since[i] % 8) : 3'd0;
    endfunction

    always @(negedge frame_clk) begin
        if (!Reset) begin
            check("m_hit", 32'(hit), 32'(m_hit[0]));
            check("m_alive", 32'(enemy_alive), 32'(m_since[0] < 0));
            check("m_exploding", 32'(enemy_exploding), 32'(m_since[0] >= 0 && m_since[0] < EF[0]));
            check("m_explode_frame", 32'(explode_frame), 32'(m_ef(0)));
            check("m_score", 32'(Score), 32'(to_bcd(m_score[0])));
            check("mf_hit", 32'(f_hit), 32'(m_hit[1]));
            check("mf_alive", 32'(f_alive), 32'(m_since[1] < 0));
            check("mf_exploding", 32'(f_expl), 32'(m_since[1] >= 0 && m_since[1] < EF[1]));
            check("mf_explode_frame", 32'(f_ef), 32'(m_ef(1)));
            check("mf_score", 32'(f_score), 32'(to_bcd(m_score[1])));
        end
    end

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #3;
        Reset = 1'b0;
    endtask

    task automatic set_boxes(input int bx, input int by, input int bs,
                             input int ex, input int ey, input int es);
        BulletX = 10'(bx); BulletY = 10'(by); BulletS = 10'(bs);
        EnemyX  = 10'(ex); EnemyY  = 10'(ey); EnemyS  = 10'(es);
    endtask

    task automatic wait_alive(input string name, input int start, input int expect_frames);
        int waited;
        waited = start;
        while (!enemy_alive && waited < 200) begin
            tick();
            waited++;
        end
        if (expect_frames > 0) check(name, 32'(waited), 32'(expect_frames));
        else check(name, 32'(enemy_alive), 32'd1);
    endtask

    task automatic run_fast(input string name, input int target, input logic [15:0] exp_score);
        int budget;
        budget = 0;
        while (f_hits < target && budget < 40000) begin
            tick();
            if (f_hit) f_hits++;
            budget++;
        end
        check({name, "_hits"}, 32'(f_hits), 32'(target));
        check({name, "_score"}, 32'(f_score), 32'(exp_score));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nh;
        Reset = 1'b1; score_clear = 1'b0; bullet_on = 1'b0; f_on = 1'b0;
        set_boxes(100, 100, 4, 100, 100, 4);
        #12;
        Reset = 1'b0;
        check("reset_alive", 32'(enemy_alive), 32'd1);
        check("reset_hit", 32'(hit), 32'd0);
        check("reset_exploding", 32'(enemy_exploding), 32'd0);
        check("reset_explode_frame", 32'(explode_frame), 32'd0);
        check("reset_score", 32'(Score), 32'h0000);

        // Idle frames with overlapping boxes but no live bullet.
        repeat (10) tick();
        check("idle_hit", 32'(hit), 32'd0);
        check("idle_alive", 32'(enemy_alive), 32'd1);
        check("idle_score", 32'(Score), 32'h0000);

        // Basic hit and full life cycle.
        set_boxes(100, 100, 4, 106, 100, 4);
        bullet_on = 1'b1;
        tick();
        check("hit_pulse", 32'(hit), 32'd1);
        check("hit_score", 32'(Score), 32'h0001);
        check("hit_exploding", 32'(enemy_exploding), 32'd1);
        check("hit_frame0", 32'(explode_frame), 32'd0);
        bullet_on = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) check("hit_drop", 32'(hit), 32'd0);
            check("explode_step", 32'(explode_frame), 32'(k));
        end
        tick();
        check("respawn_exploding", 32'(enemy_exploding), 32'd0);
        check("respawn_alive", 32'(enemy_alive), 32'd0);
        wait_alive("alive_after_68", 8, 68);

        // Touching edges is not a hit; one pixel closer is.
        set_boxes(100, 100, 4, 108, 100, 4);
        bullet_on = 1'b1;
        repeat (3) tick();
        check("edge_touch_hit", 32'(hit), 32'd0);
        check("edge_touch_alive", 32'(enemy_alive), 32'd1);
        EnemyX = 10'd107;
        tick();
        check("edge_inside_hit", 32'(hit), 32'd1);
        check("edge_inside_score", 32'(Score), 32'h0002);

        // Overlap held for 100 frames re-triggers only once the enemy is back.
        bullet_on = 1'b0;
        do_reset();
        set_boxes(100, 100, 4, 106, 100, 4);
        bullet_on = 1'b1;
        nh = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (hit) nh++;
        end
        check("held_hits", 32'(nh), 32'd2);
        check("held_score", 32'(Score), 32'h0002);

        // Asynchronous reset three frames into the explosion.
        bullet_on = 1'b0;
        do_reset();
        bullet_on = 1'b1;
        tick();
        check("r6_hit", 32'(hit), 32'd1);
        bullet_on = 1'b0;
        repeat (3) tick();
        check("r6_frame3", 32'(explode_frame), 32'd3);
        #2 Reset = 1'b1;
        #1;
        check("r6_alive", 32'(enemy_alive), 32'd1);
        check("r6_hit_low", 32'(hit), 32'd0);
        check("r6_not_exploding", 32'(enemy_exploding), 32'd0);
        Reset = 1'b0;

        // Reset during the hit frame drops the pulse at once.
        bullet_on = 1'b1;
        tick();
        check("r6b_hit", 32'(hit), 32'd1);
        #1 Reset = 1'b1;
        #1;
        check("r6b_hit_drop", 32'(hit), 32'd0);
        check("r6b_alive", 32'(enemy_alive), 32'd1);
        Reset = 1'b0;

        // score_clear on the same edge as a hit.
        tick();
        check("sc_pre_score", 32'(Score), 32'h0001);
        bullet_on = 1'b0;
        wait_alive("sc_wait_alive", 0, 0);
        bullet_on = 1'b1;
        score_clear = 1'b1;
        tick();
        check("sc_hit", 32'(hit), 32'd1);
        check("sc_score", 32'(Score), 32'h0000);
        check("sc_exploding", 32'(enemy_exploding), 32'd1);
        score_clear = 1'b0;
        bullet_on = 1'b0;

        // BCD carry and saturation on the short-cycle instance.
        do_reset();
        f_hits = 0;
        f_on = 1'b1;
        run_fast("bcd_carry", 10, 16'h0010);
        run_fast("pre_sat", 9998, 16'h9998);
        run_fast("sat_9999", 9999, 16'h9999);
        run_fast("sat_hold", 10000, 16'h9999);
        f_on = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
